// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one hold slot per writeback requester (ALU/BRU/LSU), one grant per cycle onto a registered CDB.
// Build option CDB_LSU_PRIORITY_EN: fixed priority LSU > BRU > ALU instead of round-robin.
module cdb_arbiter #(
  parameter int N_REQ     = 3,
  parameter int XLEN      = 32,
  parameter int PREG_W    = 7,
  parameter int ROB_TAG_W = 5,
  parameter int INFO_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic [N_REQ*XLEN-1:0]       req_data_i,
  input  logic [N_REQ*PREG_W-1:0]     req_prd_i,
  input  logic [N_REQ-1:0]            req_rd_used_i,
  input  logic [N_REQ*ROB_TAG_W-1:0]  req_rob_tag_i,
  input  logic [N_REQ*INFO_W-1:0]     req_info_i,
  output logic                        cdb_valid_o,
  output logic [XLEN-1:0]             cdb_data_o,
  output logic [PREG_W-1:0]           cdb_prd_o,
  output logic                        cdb_rd_used_o,
  output logic [ROB_TAG_W-1:0]        cdb_rob_tag_o,
  output logic [INFO_W-1:0]           cdb_info_o,
  output logic [N_REQ-1:0]            cdb_src_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]     r_hold_v;
  logic [XLEN-1:0]      r_data    [N_REQ];
  logic [PREG_W-1:0]    r_prd     [N_REQ];
  logic [N_REQ-1:0]     r_rd_used;
  logic [ROB_TAG_W-1:0] r_tag     [N_REQ];
  logic [INFO_W-1:0]    r_info    [N_REQ];
  logic [PTR_W-1:0]     r_rr_ptr;

  logic                 r_cdb_valid;
  logic [XLEN-1:0]      r_cdb_data;
  logic [PREG_W-1:0]    r_cdb_prd;
  logic                 r_cdb_rd_used;
  logic [ROB_TAG_W-1:0] r_cdb_tag;
  logic [INFO_W-1:0]    r_cdb_info;
  logic [N_REQ-1:0]     r_cdb_src;

  logic [N_REQ-1:0]     w_gnt;
  logic                 w_any_gnt;
  logic [PTR_W-1:0]     w_next_ptr;
  logic [XLEN-1:0]      w_sel_data;
  logic [PREG_W-1:0]    w_sel_prd;
  logic                 w_sel_rd_used;
  logic [ROB_TAG_W-1:0] w_sel_tag;
  logic [INFO_W-1:0]    w_sel_info;

  always_comb begin
    w_gnt     = '0;
    w_any_gnt = 1'b0;
`ifdef CDB_LSU_PRIORITY_EN
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (!w_any_gnt && r_hold_v[k]) begin
        w_gnt[k]  = 1'b1;
        w_any_gnt = 1'b1;
      end
    end
`else
    // Visit slots in order rr_ptr, rr_ptr+1, ... (mod N_REQ); first holder wins.
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_any_gnt && r_hold_v[i] && (((int'(r_rr_ptr) + k) % N_REQ) == i)) begin
          w_gnt[i]  = 1'b1;
          w_any_gnt = 1'b1;
        end
      end
    end
`endif
    if (flush_i) begin
      w_gnt     = '0;
      w_any_gnt = 1'b0;
    end
  end

  always_comb begin
    w_next_ptr    = r_rr_ptr;
    w_sel_data    = '0;
    w_sel_prd     = '0;
    w_sel_rd_used = 1'b0;
    w_sel_tag     = '0;
    w_sel_info    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_data    = r_data[i];
        w_sel_prd     = r_prd[i];
        w_sel_rd_used = r_rd_used[i];
        w_sel_tag     = r_tag[i];
        w_sel_info    = r_info[i];
        w_next_ptr    = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // A slot being granted this cycle frees up in time to be refilled at the same edge.
  assign req_ready_o = {N_REQ{!flush_i}} & (~r_hold_v | w_gnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_v      <= '0;
      r_rd_used     <= '0;
      r_rr_ptr      <= '0;
      r_cdb_valid   <= 1'b0;
      r_cdb_data    <= '0;
      r_cdb_prd     <= '0;
      r_cdb_rd_used <= 1'b0;
      r_cdb_tag     <= '0;
      r_cdb_info    <= '0;
      r_cdb_src     <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        r_data[i] <= '0;
        r_prd[i]  <= '0;
        r_tag[i]  <= '0;
        r_info[i] <= '0;
      end
    end else if (flush_i) begin
      r_hold_v    <= '0;
      r_cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid_i[i] && req_ready_o[i]) begin
          r_hold_v[i]  <= 1'b1;
          r_data[i]    <= req_data_i[i*XLEN +: XLEN];
          r_prd[i]     <= req_prd_i[i*PREG_W +: PREG_W];
          r_rd_used[i] <= req_rd_used_i[i];
          r_tag[i]     <= req_rob_tag_i[i*ROB_TAG_W +: ROB_TAG_W];
          r_info[i]    <= req_info_i[i*INFO_W +: INFO_W];
        end else if (w_gnt[i]) begin
          r_hold_v[i] <= 1'b0;
        end
      end
      r_cdb_valid <= w_any_gnt;
      if (w_any_gnt) begin
        r_cdb_data    <= w_sel_data;
        r_cdb_prd     <= w_sel_prd;
        r_cdb_rd_used <= w_sel_rd_used;
        r_cdb_tag     <= w_sel_tag;
        r_cdb_info    <= w_sel_info;
        r_cdb_src     <= w_gnt;
`ifdef CDB_LSU_PRIORITY_EN
        r_rr_ptr      <= '0;
`else
        r_rr_ptr      <= w_next_ptr;
`endif
      end
    end
  end

  assign cdb_valid_o   = r_cdb_valid;
  assign cdb_data_o    = r_cdb_data;
  assign cdb_prd_o     = r_cdb_prd;
  assign cdb_rd_used_o = r_cdb_rd_used;
  assign cdb_rob_tag_o = r_cdb_tag;
  assign cdb_info_o    = r_cdb_info;
  assign cdb_src_o     = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a slot/queue-level reference model.
module tb_cdb_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic [6:0]  prd;
    logic        rdu;
    logic [4:0]  tag;
    logic [7:0]  info;
  } pl_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [2:0]  valid;
  pl_t         t_pl [3];

  logic [2:0]  req_ready_o;
  logic [95:0] req_data_i;
  logic [20:0] req_prd_i;
  logic [2:0]  req_rd_used_i;
  logic [14:0] req_rob_tag_i;
  logic [23:0] req_info_i;
  logic        cdb_valid_o;
  logic [31:0] cdb_data_o;
  logic [6:0]  cdb_prd_o;
  logic        cdb_rd_used_o;
  logic [4:0]  cdb_rob_tag_o;
  logic [7:0]  cdb_info_o;
  logic [2:0]  cdb_src_o;

  always_comb begin
    req_data_i    = '0;
    req_prd_i     = '0;
    req_rd_used_i = '0;
    req_rob_tag_i = '0;
    req_info_i    = '0;
    for (int i = 0; i < 3; i++) begin
      req_data_i[i*32 +: 32]   = t_pl[i].data;
      req_prd_i[i*7 +: 7]      = t_pl[i].prd;
      req_rd_used_i[i]         = t_pl[i].rdu;
      req_rob_tag_i[i*5 +: 5]  = t_pl[i].tag;
      req_info_i[i*8 +: 8]     = t_pl[i].info;
    end
  end

  cdb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .req_valid_i  (valid),
    .req_ready_o  (req_ready_o),
    .req_data_i   (req_data_i),
    .req_prd_i    (req_prd_i),
    .req_rd_used_i(req_rd_used_i),
    .req_rob_tag_i(req_rob_tag_i),
    .req_info_i   (req_info_i),
    .cdb_valid_o  (cdb_valid_o),
    .cdb_data_o   (cdb_data_o),
    .cdb_prd_o    (cdb_prd_o),
    .cdb_rd_used_o(cdb_rd_used_o),
    .cdb_rob_tag_o(cdb_rob_tag_o),
    .cdb_info_o   (cdb_info_o),
    .cdb_src_o    (cdb_src_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which slots hold a result, their contents, the rotation start, the bus.
  bit [2:0] m_hv;
  pl_t      m_slot [3];
  int       m_rr;
  pl_t      m_cdb;
  bit       m_cdb_v;
  logic [2:0] m_src;
  bit [2:0] last_acc;
  int       acc_cnt [32];
  int       bc_cnt  [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hv = '0;
    m_rr = 0;
    m_cdb = '0;
    m_cdb_v = 1'b0;
    m_src = '0;
    for (int i = 0; i < 3; i++) m_slot[i] = '0;
  endtask

  task automatic clear_counts();
    for (int t = 0; t < 32; t++) begin
      acc_cnt[t] = 0;
      bc_cnt[t]  = 0;
    end
  endtask

  // Caller has set flush/valid/t_pl; evaluates one cycle of model and DUT.
  task automatic step();
    int g;
    logic [2:0] m_ready;
    #1;
    g = -1;
`ifdef CDB_LSU_PRIORITY_EN
    for (int k = 2; k >= 0; k--) if (g < 0 && m_hv[k]) g = k;
`else
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_rr + k) % 3;
      if (g < 0 && m_hv[idx]) g = idx;
    end
`endif
    if (flush) g = -1;
    for (int i = 0; i < 3; i++) m_ready[i] = !flush && (!m_hv[i] || g == i);
    chk("req_ready", req_ready_o, m_ready);
    last_acc = valid & m_ready;
    if (flush) begin
      m_hv = '0;
      m_cdb_v = 1'b0;
    end else begin
      if (g >= 0) begin
        m_cdb   = m_slot[g];
        m_cdb_v = 1'b1;
        m_src   = 3'(1 << g);
        m_hv[g] = 1'b0;
        m_rr    = (g + 1) % 3;
      end else begin
        m_cdb_v = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (last_acc[i]) begin
          m_slot[i] = t_pl[i];
          m_hv[i]   = 1'b1;
          acc_cnt[t_pl[i].tag]++;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("cdb_valid", cdb_valid_o, m_cdb_v);
    chk("cdb_data", cdb_data_o, m_cdb.data);
    chk("cdb_prd", cdb_prd_o, m_cdb.prd);
    chk("cdb_rd_used", cdb_rd_used_o, m_cdb.rdu);
    chk("cdb_rob_tag", cdb_rob_tag_o, m_cdb.tag);
    chk("cdb_info", cdb_info_o, m_cdb.info);
    if (m_cdb_v) chk("cdb_src", cdb_src_o, m_src);
    if (cdb_valid_o) bc_cnt[cdb_rob_tag_o]++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    valid = '0;
    for (int i = 0; i < 3; i++) t_pl[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    clear_counts();
    last_acc = '0;
  endtask

  function automatic pl_t mk(input int tag, input logic rdu);
    pl_t p;
    p.data = $urandom;
    p.prd  = 7'($urandom);
    p.rdu  = rdu;
    p.tag  = 5'(tag);
    p.info = 8'($urandom);
    return p;
  endfunction

  int n_tag [3];
  int first_lsu;
  int bad;
  logic [2:0] exp_src [6];

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    valid = '0;
    last_acc = '0;
    for (int i = 0; i < 3; i++) t_pl[i] = '0;

    // Reset then idle
    do_reset();
    #1;
    chk("rst_valid", cdb_valid_o, 0);
    chk("rst_ready", req_ready_o, 3'b111);
    chk("rst_data", cdb_data_o, 0);
    chk("rst_prd", cdb_prd_o, 0);
    chk("rst_rdu", cdb_rd_used_o, 0);
    chk("rst_tag", cdb_rob_tag_o, 0);
    chk("rst_info", cdb_info_o, 0);
    chk("rst_src", cdb_src_o, 0);
    step();
    chk("idle_valid", cdb_valid_o, 0);

    // Single ALU request: broadcast two edges later, then gone
    t_pl[0] = '{data: 32'hDEADBEEF, prd: 7'd5, rdu: 1'b1, tag: 5'd3, info: 8'h00};
    valid = 3'b001;
    step();
    chk("alu_not_yet", cdb_valid_o, 0);
    valid = 3'b000;
    step();
    chk("alu_valid", cdb_valid_o, 1);
    chk("alu_data", cdb_data_o, 32'hDEADBEEF);
    chk("alu_prd", cdb_prd_o, 5);
    chk("alu_tag", cdb_rob_tag_o, 3);
    chk("alu_src", cdb_src_o, 3'b001);
    step();
    chk("alu_done", cdb_valid_o, 0);

    // All three requesters continuously valid
    do_reset();
    exp_src[0] = 3'b001; exp_src[1] = 3'b010; exp_src[2] = 3'b100;
    exp_src[3] = 3'b001; exp_src[4] = 3'b010; exp_src[5] = 3'b100;
    for (int i = 0; i < 3; i++) n_tag[i] = 0;
    for (int c = 0; c < 7; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (c == 0 || last_acc[i]) begin
          t_pl[i] = mk(i * 10 + n_tag[i], 1'b1);
          n_tag[i]++;
        end
      end
      valid = 3'b111;
`ifndef CDB_LSU_PRIORITY_EN
      #1;
      if (c >= 1) chk("rr_ready_on_grant", req_ready_o[(c - 1) % 3], 1);
`endif
      step();
`ifndef CDB_LSU_PRIORITY_EN
      if (c >= 1) chk("rr_src_seq", cdb_src_o, exp_src[c - 1]);
`endif
    end
    valid = '0;
    repeat (4) step();
    bad = 0;
    for (int t = 0; t < 32; t++) if (acc_cnt[t] != bc_cnt[t]) bad++;
    chk("no_loss_dup", bad, 0);

    // LSU held while ALU presents continuously
    do_reset();
    first_lsu = -1;
    t_pl[2] = mk(25, 1'b1);
    n_tag[0] = 0;
    t_pl[0] = mk(n_tag[0], 1'b1);
    valid = 3'b101;
    for (int c = 0; c < 5; c++) begin
      step();
      if (last_acc[2]) valid[2] = 1'b0;
      if (last_acc[0]) begin
        n_tag[0]++;
        t_pl[0] = mk(n_tag[0], 1'b1);
      end
      if (first_lsu < 0 && cdb_valid_o && cdb_src_o == 3'b100) first_lsu = c;
    end
`ifdef CDB_LSU_PRIORITY_EN
    chk("lsu_first", first_lsu, 1);
`else
    chk("lsu_within2", first_lsu, 2);
`endif
    valid = '0;
    repeat (3) step();

    // Flush with all slots full and the bus busy
    do_reset();
    clear_counts();
    t_pl[0] = mk(1, 1'b1); t_pl[1] = mk(11, 1'b1); t_pl[2] = mk(21, 1'b1);
    valid = 3'b111;
    step();
    t_pl[0] = mk(2, 1'b1);
    valid = 3'b001;
    step();
    chk("pre_flush_valid", cdb_valid_o, 1);
    flush = 1'b1;
    t_pl[0] = mk(3, 1'b1); t_pl[1] = mk(12, 1'b1); t_pl[2] = mk(22, 1'b1);
    valid = 3'b111;
    #1;
    chk("flush_ready", req_ready_o, 3'b000);
    step();
    chk("flush_valid", cdb_valid_o, 0);
    flush = 1'b0;
    valid = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_flush_idle", cdb_valid_o, 0);
    end
    chk("flushed_tags_absent", bc_cnt[2] + bc_cnt[11] + bc_cnt[21] + bc_cnt[3] + bc_cnt[12] + bc_cnt[22], 0);

    // Store result with rd_used=0
    t_pl[2] = mk(9, 1'b0);
    valid = 3'b100;
    step();
    valid = '0;
    step();
    chk("store_valid", cdb_valid_o, 1);
    chk("store_rdu", cdb_rd_used_o, 0);
    chk("store_tag", cdb_rob_tag_o, 9);
    chk("store_src", cdb_src_o, 3'b100);

    // Randomized traffic with occasional flush
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (last_acc[i]) valid[i] = 1'b0;
        if (!valid[i] && ($urandom_range(3, 0) != 0)) begin
          t_pl[i] = mk($urandom_range(31, 0), 1'($urandom));
          valid[i] = 1'b1;
        end
      end
      flush = ($urandom_range(24, 0) == 0);
      step();
    end
    flush = 1'b0;
    valid = '0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
